// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the image-DRAM access controller.
package dram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  localparam logic SIZE_BYTE      = 1'b0;
  localparam logic SIZE_WORD      = 1'b1;
  localparam int   BYTES_PER_WORD = 4;

  // Byte counter value of the final byte issued for an access of this size.
  function automatic logic [2:0] last_cnt(input logic size);
    return (size == SIZE_WORD) ? 3'(BYTES_PER_WORD - 1) : 3'd0;
  endfunction

endpackage

// File: rtl/dram_access_ctrl_if.sv
// Requester-side bus of the DRAM access controller: two request ports and one shared response.
interface dram_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [31:0]       req_wdata0;
  logic [31:0]       req_wdata1;
  logic              rsp_valid;
  logic              rsp_id;
  logic [31:0]       rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_id, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata
  );
endinterface

// File: rtl/dram_access_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant remembers the requester granted most recently.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (update)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/dram_access_ctrl.sv
// Arbitrates two requesters onto a byte-wide DRAM, serialising word accesses little-endian.
module dram_access_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dram_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0]  dram_addr,
  output logic [7:0]         dram_wdata,
  output logic               dram_we,
  output logic               dram_re,
  input  logic [7:0]         dram_rdata,
  output logic               busy
);

  state_t            state, state_nx;
  logic [2:0]        cnt;
  logic              we_q, size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0][7:0]   wdata_q;
  logic [3:0][7:0]   rbuf, rmerge;
  logic [1:0]        cap_idx;
  logic [1:0]        grant;
  logic              last_grant;
  logic              take;
  logic              sel;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus.req_valid),
    .update     (take),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign take    = (state == IDLE) && (|bus.req_valid);
  assign sel     = grant[1];
  assign busy    = (state != IDLE);
  // The arbiter's last grant is the owner of the access in flight.
  assign bus.rsp_id    = busy & last_grant;
  assign bus.rsp_valid = (state == RESP);

  // Byte issued last cycle lands at index cnt-1; DRAIN uses cnt after the final increment.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    rmerge          = rbuf;
    rmerge[cap_idx] = dram_rdata;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 2'b00;
    dram_addr     = '0;
    dram_wdata    = '0;
    dram_we       = 1'b0;
    dram_re       = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = grant;
        if (take) state_nx = XFER;
      end
      XFER: begin
        dram_addr = addr_q + ADDR_W'(cnt);
        if (we_q) begin
          dram_we    = 1'b1;
          dram_wdata = wdata_q[cnt[1:0]];
        end else begin
          dram_re    = 1'b1;
        end
        if (cnt == last_cnt(size_q)) state_nx = we_q ? RESP : DRAIN;
      end
      DRAIN:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      size_q        <= SIZE_BYTE;
      bus.rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        cnt    <= '0;
        we_q   <= bus.req_we[sel];
        size_q <= bus.req_size[sel];
      end else if (state == XFER) begin
        cnt <= cnt + 3'd1;
      end
      if (state == DRAIN) bus.rsp_rdata <= rmerge;
    end
  end

  // Request payload and read assembly buffer.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= sel ? bus.req_addr1  : bus.req_addr0;
      wdata_q <= sel ? bus.req_wdata1 : bus.req_wdata0;
      rbuf    <= '0;
    end else if (state == XFER && cnt != 3'd0) begin
      rbuf    <= rmerge;
    end
  end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl with a behavioural byte-wide DRAM model.
module tb_dram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dram_addr;
  logic [7:0]  dram_wdata;
  logic        dram_we, dram_re;
  logic [7:0]  dram_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_cnt = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];

  dram_access_ctrl_if #(.ADDR_W(16)) bus ();

  dram_access_ctrl #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_re    (dram_re),
    .dram_rdata (dram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dram_we) begin
      mem[dram_addr] <= dram_wdata;
      log_addr.push_back(dram_addr);
      log_data.push_back(dram_wdata);
    end
    if (dram_re) dram_rdata <= mem[dram_addr];
  end

  always @(negedge clk) if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_ready"},  32'(bus.req_ready), 32'd0);
    chk({p, "_rspv"},   32'(bus.rsp_valid), 32'd0);
    chk({p, "_rspid"},  32'(bus.rsp_id),    32'd0);
    chk({p, "_rdata"},  bus.rsp_rdata,      32'd0);
    chk({p, "_addr"},   32'(dram_addr),     32'd0);
    chk({p, "_wdata"},  32'(dram_wdata),    32'd0);
    chk({p, "_we"},     32'(dram_we),       32'd0);
    chk({p, "_re"},     32'(dram_re),       32'd0);
    chk({p, "_busy"},   32'(busy),          32'd0);
  endtask

  // Presents a request, waits for the handshake, then withdraws valid.
  task automatic issue(input int id, input logic we, input logic size,
                       input logic [15:0] addr, input logic [31:0] wd, output int t0);
    @(negedge clk);
    bus.req_we[id]   = we;
    bus.req_size[id] = size;
    if (id == 0) begin bus.req_addr0 = addr; bus.req_wdata0 = wd; end
    else         begin bus.req_addr1 = addr; bus.req_wdata1 = wd; end
    bus.req_valid[id] = 1'b1;
    t0 = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.req_ready[id]) begin t0 = cyc; break; end
      @(negedge clk);
    end
    if (t0 < 0) chk("hs_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int t0, output int lat, output logic [31:0] rd, output logic id);
    lat = -1; rd = '0; id = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.rsp_valid) begin lat = cyc - t0; rd = bus.rsp_rdata; id = bus.rsp_id; break; end
      @(negedge clk);
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, lat, ls, r1c, r0c, viol, rc;
    logic [31:0] rd;
    logic id;
    int order [$];

    bus.req_valid = '0; bus.req_we = '0; bus.req_size = '0;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    repeat (3) @(negedge clk);
    #1 check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // word write A5A5A5A5 @0010 by requester 0
    ls = log_addr.size();
    issue(0, 1'b1, 1'b1, 16'h0010, 32'hA5A5_A5A5, t0);
    wait_rsp(t0, lat, rd, id);
    chk("ww_lat", 32'(lat), 32'd5);
    chk("ww_id", 32'(id), 32'd0);
    chk("ww_nbytes", 32'(log_addr.size() - ls), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ww_addr%0d", i), 32'(log_addr[ls+i]), 32'h0010 + 32'(i));
      chk($sformatf("ww_data%0d", i), 32'(log_data[ls+i]), 32'hA5);
    end

    issue(0, 1'b0, 1'b1, 16'h0010, 32'h0, t0);
    wait_rsp(t0, lat, rd, id);
    chk("wr_lat", 32'(lat), 32'd6);
    chk("wr_data", rd, 32'hA5A5_A5A5);
    chk("wr_id", 32'(id), 32'd0);

    // byte write 150 @0020 by requester 1, then read it back
    ls = log_addr.size();
    issue(1, 1'b1, 1'b0, 16'h0020, 32'hFFFF_FF96, t0);
    wait_rsp(t0, lat, rd, id);
    chk("bw_lat", 32'(lat), 32'd2);
    chk("bw_id", 32'(id), 32'd1);
    chk("bw_nbytes", 32'(log_addr.size() - ls), 32'd1);
    chk("bw_addr", 32'(log_addr[ls]), 32'h0020);
    chk("bw_data", 32'(log_data[ls]), 32'h96);

    issue(1, 1'b0, 1'b0, 16'h0020, 32'h0, t0);
    wait_rsp(t0, lat, rd, id);
    chk("br_lat", 32'(lat), 32'd3);
    chk("br_data", rd, 32'h0000_0096);
    chk("br_id", 32'(id), 32'd1);

    // address wrap at FFFE
    ls = log_addr.size();
    issue(0, 1'b1, 1'b1, 16'hFFFE, 32'h4433_2211, t0);
    wait_rsp(t0, lat, rd, id);
    chk("wrap_nbytes", 32'(log_addr.size() - ls), 32'd4);
    chk("wrap_a0", 32'(log_addr[ls]),   32'hFFFE);
    chk("wrap_a1", 32'(log_addr[ls+1]), 32'hFFFF);
    chk("wrap_a2", 32'(log_addr[ls+2]), 32'h0000);
    chk("wrap_a3", 32'(log_addr[ls+3]), 32'h0001);
    chk("wrap_d0", 32'(log_data[ls]),   32'h11);
    chk("wrap_d1", 32'(log_data[ls+1]), 32'h22);
    chk("wrap_d2", 32'(log_data[ls+2]), 32'h33);
    chk("wrap_d3", 32'(log_data[ls+3]), 32'h44);

    issue(1, 1'b0, 1'b1, 16'hFFFE, 32'h0, t0);
    wait_rsp(t0, lat, rd, id);
    chk("wrapr_lat", 32'(lat), 32'd6);
    chk("wrapr_data", rd, 32'h4433_2211);
    chk("wrapr_id", 32'(id), 32'd1);

    // requester 1 raises valid while requester 0 is transferring
    issue(0, 1'b1, 1'b1, 16'h0040, 32'h1122_3344, t0);
    bus.req_we[1] = 1'b0; bus.req_size[1] = 1'b0; bus.req_addr1 = 16'h0020;
    bus.req_valid[1] = 1'b1;
    r1c = -1; r0c = -1; viol = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.rsp_valid && r0c < 0) r0c = cyc;
      if (bus.req_ready[1]) begin
        if (busy) viol++;
        r1c = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("busy_viol", 32'(viol), 32'd0);
    chk("busy_rsp0_lat", 32'(r0c - t0), 32'd5);
    chk("busy_grant1", 32'(r1c), 32'(r0c + 1));
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_rsp(r1c, lat, rd, id);
    chk("busy_r1_data", rd, 32'h0000_0096);
    chk("busy_r1_id", 32'(id), 32'd1);

    // reset in the third XFER cycle of a word write
    issue(0, 1'b1, 1'b1, 16'h0050, 32'h0, t0);
    wait_rsp(t0, lat, rd, id);
    issue(0, 1'b1, 1'b1, 16'h0050, 32'hDDCC_BBAA, t0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mr_we_pre", 32'(dram_we), 32'd1);
    chk("mr_addr_pre", 32'(dram_addr), 32'h0052);
    rc = rsp_cnt;
    rst_n = 1'b0;
    #1 check_reset("mr");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("mr_no_rsp", 32'(rsp_cnt), 32'(rc));
    chk("mr_idle", 32'(busy), 32'd0);
    chk("mr_m50", 32'(mem[16'h0050]), 32'hAA);
    chk("mr_m51", 32'(mem[16'h0051]), 32'hBB);
    chk("mr_m52", 32'(mem[16'h0052]), 32'h00);
    chk("mr_m53", 32'(mem[16'h0053]), 32'h00);

    // both requesters hold word reads from reset
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_we = 2'b00; bus.req_size = 2'b11;
    bus.req_addr0 = 16'h0010; bus.req_addr1 = 16'hFFFE;
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 80 && order.size() < 4; k++) begin
      #1;
      if (bus.req_ready == 2'b11) chk("arb_onehot", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready != 2'b00) order.push_back(int'(bus.req_ready[1]));
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    chk("arb_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk($sformatf("arb_grant%0d", i), 32'(order[i]), 32'(i % 2));
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    #1 chk("arb_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_access_ctrl.md
# dram_access_ctrl

Sequencer and arbiter for the byte-wide image DRAM behind the memory data register path. Two requesters share the DRAM through this block: port 0 is the control unit and port 1 is the convolution/image-loader engine. Each request is a byte or 32-bit word read or write. Word accesses are serialized into four little-endian byte accesses, and the result is returned as a single response.

## Interface
Parameters:
- ADDR_W, 16, DRAM byte-address width; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; request is taken on the cycle where valid & ready.
- req_we  in  2  1 = write, 0 = read.
- req_size  in  2  0 = byte, 1 = word.
- req_addr0, req_addr1  in  ADDR_W  base byte address.
- req_wdata0, req_wdata1  in  32  write data; byte k = bits [8k+7:8k]; byte writes use [7:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_rdata  out  32  read data; byte reads zero-extended; held until the next rsp_valid.
- dram_addr  out  ADDR_W  DRAM byte address.
- dram_wdata  out  8  DRAM write byte.
- dram_we  out  1  DRAM write strobe.
- dram_re  out  1  DRAM read strobe; dram_rdata valid the following cycle.
- dram_rdata  in  8  DRAM read byte.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, XFER, DRAIN, RESP.
- **IDLE.** If any req_valid is set, grant one requester and assert its req_ready combinationally in the same cycle. On the handshake, latch we, size, addr, wdata and id; set cnt = 0; go to XFER.
- **Arbitration.** Round-robin over two requesters.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is chosen.
  - After reset, last-grant = 1, so requester 0 wins the first tie.
- **XFER.**
  - Drive dram_addr = (base + cnt) mod 2^ADDR_W.
  - Write: dram_we = 1 and dram_wdata = byte cnt.
  - Read: dram_re = 1, and the byte issued in the previous cycle is captured into rsp_rdata byte cnt-1.
  - cnt increments each cycle. The last byte is cnt = 0 for a byte access and cnt = 3 for a word access.
  - After the last byte: write goes to RESP; read goes to DRAIN.
- **DRAIN** (reads only): capture the final byte from dram_rdata, then go to RESP.
- **RESP:** rsp_valid = 1 and rsp_id = latched id, then go to IDLE.
- **Response channel:** it has no backpressure; the requester must sample rsp_valid.
- **Requester rules:** a requester holds req_valid and its fields stable until it sees req_ready. Changing them before the handshake is illegal and is not checked.
- **Fairness:** a requester is never granted twice in a row while the other is valid.

## Timing
- **Reset values:** req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_rdata = 0, dram_addr = 0, dram_wdata = 0, dram_we = 0, dram_re = 0, busy = 0, last-grant = 1.
- **Latency** (handshake at T0, rsp_valid at):
  - byte write: T2
  - word write: T5
  - byte read: T3
  - word read: T6
- **Throughput:** the next handshake is possible at the earliest in the cycle after RESP.
- **Reset mid-operation:**
  - dram_we and dram_re drop immediately (asynchronously).
  - Any partial word write stays in DRAM; there is no rollback.
  - No response is issued, and the FSM returns to IDLE.
- **Address wrap:** a word at base 16'hFFFE touches FFFE, FFFF, 0000, 0001.
- **Inputs while busy:** req_valid assertions while busy are ignored (req_ready = 0) and are served later by arbitration.

## Structure
- **Package dram_ctrl_pkg:**
  - state enum {IDLE, XFER, DRAIN, RESP}
  - SIZE_BYTE = 0, SIZE_WORD = 1
  - BYTES_PER_WORD = 4
- **Sub-module rr_arbiter2:** inputs are the 2-bit request and an update strobe; outputs are a one-hot grant and the last-grant register. The FSM and the byte counter stay in the top module.

## Test plan
- **Word write, then word read.**
  - Stimulus: requester 0 writes 32'hA5A5A5A5 at 16'h0010, then reads 16'h0010 back.
  - Required: dram_we is high for 4 cycles with addr 0010..0013 and data A5 each cycle. Read rsp_rdata = A5A5A5A5 with rsp_id = 0, and rsp_valid lands at T5 for the write and T6 for the read.
- **Byte read.**
  - Stimulus: DRAM model returns 8'd150 at 16'h0020; requester 1 issues a byte read there.
  - Required: rsp_rdata = 32'h00000096, rsp_id = 1, rsp_valid at T3.
- **Arbitration.**
  - Stimulus: both requesters hold word reads valid continuously from reset.
  - Required: grant order 0, 1, 0, 1. No requester is granted twice in a row.
- **Address wrap.**
  - Stimulus: word write 32'h44332211 at 16'hFFFE.
  - Required: bytes 11, 22, 33, 44 land at FFFE, FFFF, 0000, 0001.
- **Reset mid-operation.**
  - Stimulus: assert rst_n = 0 in the third XFER cycle of a word write.
  - Required: dram_we drops the same cycle, no rsp_valid occurs, and all outputs are at reset values.
- **Request while busy.**
  - Stimulus: requester 1 raises valid during requester 0's XFER.
  - Required: req_ready[1] stays 0 until IDLE, then requester 1 is granted the cycle after RESP.
